// File: rtl/t_pulse_gen_pkg.sv
// Shared definitions for the push-button pulse generator: FSM state
// encodings, edge-select constants and helpers that decode the edge select.
package t_pulse_gen_pkg;

    // Debounce FSM states; encodings are fixed so other stages can decode them.
    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } pg_state_t;

    // Which accepted edge produces a toggle pulse.
    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_BOTH = 2;

    // True when an accepted press (0->1) must emit a pulse.
    function automatic logic pulse_on_rise(input int unsigned sel);
        return (sel == EDGE_RISE) || (sel == EDGE_BOTH);
    endfunction

    // True when an accepted release (1->0) must emit a pulse.
    function automatic logic pulse_on_fall(input int unsigned sel);
        return (sel == EDGE_FALL) || (sel == EDGE_BOTH);
    endfunction

    // True for the states in which a candidate change is being qualified.
    function automatic logic is_wait(input pg_state_t st);
        return (st == WAIT_HI) || (st == WAIT_LO);
    endfunction

endpackage

// File: rtl/t_pulse_gen_sync_ff.sv
// Multi-stage flop chain bringing an asynchronous level into the clk domain.
// Reusable by any button-driven stage; the last stage is the only safe tap.
module sync_ff #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the raw level through the chain; synchronous clear on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/t_pulse_gen.sv
// Push-button front end for t_ff: synchronises a bouncing button, accepts a
// level change only after it has been stable long enough, and emits a single
// registered toggle pulse per accepted edge selected by EDGE_SEL.
module t_pulse_gen
    import t_pulse_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned EDGE_SEL        = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic t,
    output logic btn_level,
    output logic busy
);

    localparam int unsigned      CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic             RISE_PULSE = pulse_on_rise(EDGE_SEL);
    localparam logic             FALL_PULSE = pulse_on_fall(EDGE_SEL);

    logic             s;
    pg_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             t_q, t_n;
    logic             level_q, level_n;
    logic             busy_q, busy_n;

    sync_ff #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (btn_in),
        .q    (s)
    );

    // State, stable counter and output registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE_LO;
            cnt     <= '0;
            t_q     <= 1'b0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            t_q     <= t_n;
            level_q <= level_n;
            busy_q  <= busy_n;
        end
    end

    // Next-state logic: a change commits only when s still differs on the
    // edge where cnt has reached DEBOUNCE_CYCLES; any flip, including one on
    // that commit edge, returns to the prior IDLE state without a pulse.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        level_n = level_q;
        t_n     = 1'b0;
        case (state)
            IDLE_LO: begin
                if (s) begin
                    state_n = WAIT_HI;
                    cnt_n   = CNT_ONE;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_n = IDLE_LO;
                    cnt_n   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_n = IDLE_HI;
                    cnt_n   = '0;
                    level_n = 1'b1;
                    t_n     = RISE_PULSE;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            IDLE_HI: begin
                if (!s) begin
                    state_n = WAIT_LO;
                    cnt_n   = CNT_ONE;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_n = IDLE_HI;
                    cnt_n   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_n = IDLE_LO;
                    cnt_n   = '0;
                    level_n = 1'b0;
                    t_n     = FALL_PULSE;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: begin
                state_n = IDLE_LO;
                cnt_n   = '0;
                level_n = 1'b0;
            end
        endcase
        busy_n = is_wait(state_n);
    end

    assign t         = t_q;
    assign btn_level = level_q;
    assign busy      = busy_q;

endmodule
